tft_spi_tx: RTL and testbench
=============================

// Module: tft_spi_tx
// PURPOSE
//  Byte-level SPI transmitter for the TFT panel (SPI mode 0, MSB first, write-only).
//  Consumer end of the tft_transmit/tft_dc/tft_data/tft_busy handshake driven by the
//  init sequencer and the frame renderer; drives the panel's SCK/MOSI/CS#/DC pins.
//  One byte in flight; a new byte is accepted only when idle.
// PARAMETERS
//  CLK_DIV  2  system clocks per SCK half-period; legal range 1..255
// PORTS
//  clk             in   1  system clock; single clock domain
//  global_reset_n  in   1  synchronous reset, active-low
//  tft_transmit    in   1  byte request, sampled at posedge; 1-cycle pulse
//  tft_dc          in   1  0 = command byte, 1 = data byte
//  tft_data        in   8  byte to send
//  tft_busy        out  1  1 = request ignored; transmitter occupied
//  spi_sck         out  1  SPI clock, idle low
//  spi_mosi        out  1  serial data, MSB first
//  spi_cs_n        out  1  chip select, active-low
//  spi_dc          out  1  D/C# pin to the panel
// BEHAVIOUR
//  - Reset (global_reset_n==0 at posedge): state=IDLE; sck=0, mosi=0, cs_n=1, dc=0,
//    busy_r=0, bit counter=0, divider=0. Reset mid-byte abandons the byte; pins idle next edge.
//  - tft_busy = busy_r | tft_transmit (combinational). The request cycle itself reads
//    busy, so a requester that checks ~tft_busy every cycle never issues twice.
//  - Accept: IDLE & tft_transmit at posedge -> latch {tft_dc,tft_data}; next cycle:
//    cs_n=0, dc=latched dc, mosi=data[7], sck=0, busy_r=1, state=SHIFT.
//  - SHIFT: divider counts 0..CLK_DIV-1 per half-period. End of low half: sck->1
//    (panel samples). End of high half: sck->0, bit count+1, mosi->next bit.
//  - After 8th falling edge: cs_n=1, mosi=0, state=IDLE, busy_r=0 on that edge
//    (macro off). busy_r high for exactly 16*CLK_DIV cycles per byte.
//  - tft_transmit while busy_r=1: ignored; in-flight byte and latched data unaffected.
//  - Back-to-back: request in the first idle cycle -> next byte starts next cycle;
//    cs_n high for exactly 1 cycle between bytes (macro off).
//  - dc changes only on accept; stable for the whole byte.
//  - CLK_DIV is a parameter only; no runtime rate change.
//  - Divider width 8 bits, bit counter 3 bits + done flag; no wrap beyond 8 bits/byte.
// CONFIGURATION
//  TFT_SPI_CS_GAP_EN defined: after the 8th falling edge, state=GAP; cs_n=1, sck=0,
//    busy_r stays 1 for a further 2*CLK_DIV cycles, then IDLE. Min cs_n-high between
//    bytes = 2*CLK_DIV+1 cycles; busy_r 18*CLK_DIV cycles per byte.
//  TFT_SPI_CS_GAP_EN undefined: no GAP state; timing as in BEHAVIOUR.
// TESTING (CLK_DIV=2 unless stated)
//  1. Pulse transmit, dc=0, data=8'hA5 -> 8 sck rising edges; mosi at each =
//     1,0,1,0,0,1,0,1; spi_dc=0; cs_n low 32 cycles; busy_r high 32 cycles.
//  2. tft_busy in request cycle -> 1 while busy_r still 0; sequencer-style requester
//     sending 3 bytes (2C,FF,00) -> exactly 24 rising sck edges, bytes in order.
//  3. Second pulse (data=8'h3C) 5 cycles into byte 8'hA5 -> ignored; MOSI stream is
//     A5 only; busy drops after 32 cycles.
//  4. global_reset_n=0 at cycle 10 of a byte -> next cycle cs_n=1, sck=0, mosi=0,
//     tft_busy=0; fresh request for 8'h81 then transmits cleanly.
//  5. CLK_DIV=1, back-to-back 8'hFF,8'h00 -> each byte 16 cycles, cs_n high 1 cycle between.
//  6. TFT_SPI_CS_GAP_EN defined, back-to-back bytes -> cs_n high 5 cycles between bytes,
//     busy_r 36 cycles per byte.

Source files
------------

// File: rtl/tft_spi_tx_if.sv
// Byte-request handshake between the TFT init sequencer / renderer and the SPI transmitter.
interface tft_spi_tx_if;
  logic       tft_transmit;
  logic       tft_dc;
  logic [7:0] tft_data;
  logic       tft_busy;

  modport master (output tft_transmit, tft_dc, tft_data, input tft_busy);
  modport slave  (input tft_transmit, tft_dc, tft_data, output tft_busy);
endinterface

// File: rtl/tft_spi_tx.sv
// Write-only SPI mode-0 byte transmitter for the TFT panel, MSB first, one byte in flight.
// Optional TFT_SPI_CS_GAP_EN adds a guaranteed CS#-high gap of 2*CLK_DIV cycles after each byte.
module tft_spi_tx #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          global_reset_n,
  tft_spi_tx_if.slave   tft,
  output logic          spi_sck,
  output logic          spi_mosi,
  output logic          spi_cs_n,
  output logic          spi_dc
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] bit_q, bit_d;
  logic       sck_q, sck_d;
  logic       cs_n_q, cs_n_d;
  logic       dc_q, dc_d;
  logic       busy_q, busy_d;
`ifdef TFT_SPI_CS_GAP_EN
  logic       gap_half_q, gap_half_d;
`endif

  always_ff @(posedge clk) begin
    if (!global_reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef TFT_SPI_CS_GAP_EN
      gap_half_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
`ifdef TFT_SPI_CS_GAP_EN
      gap_half_q <= gap_half_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    busy_d  = busy_q;
`ifdef TFT_SPI_CS_GAP_EN
    gap_half_d = gap_half_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tft.tft_transmit) begin
          state_d = SHIFT;
          sh_d    = tft.tft_data;
          dc_d    = tft.tft_dc;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == 3'd7) begin
              // Clearing the shifter parks MOSI low between bytes.
              sh_d   = '0;
              cs_n_d = 1'b1;
`ifdef TFT_SPI_CS_GAP_EN
              state_d    = GAP;
              gap_half_d = 1'b0;
`else
              state_d = IDLE;
              busy_d  = 1'b0;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
              sh_d  = {sh_q[6:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
`ifdef TFT_SPI_CS_GAP_EN
      GAP: begin
        // Two divider periods keep CS# high long enough for the panel's deselect time.
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (gap_half_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            gap_half_d = 1'b1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign tft.tft_busy = busy_q | tft.tft_transmit;
  assign spi_sck      = sck_q;
  assign spi_mosi     = sh_q[7];
  assign spi_cs_n     = cs_n_q;
  assign spi_dc       = dc_q;

endmodule

// File: tb/tb_tft_spi_tx.sv
// Bench for tft_spi_tx: unit 0 at CLK_DIV=2, unit 1 at CLK_DIV=1; SPI pins decoded by a monitor.
module tb_tft_spi_tx;

`ifdef TFT_SPI_CS_GAP_EN
  localparam int BUSY_MUL = 18;
  localparam bit GAP_EN   = 1'b1;
`else
  localparam int BUSY_MUL = 16;
  localparam bit GAP_EN   = 1'b0;
`endif

  logic clk = 1'b0;
  logic global_reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] tx  = '0;
  logic [1:0] dcv = '0;
  logic [7:0] dat [2] = '{8'h00, 8'h00};
  logic [1:0] busy_w, sck, mosi, csn, dcp;

  tft_spi_tx_if if0 ();
  tft_spi_tx_if if1 ();
  assign if0.tft_transmit = tx[0];
  assign if0.tft_dc       = dcv[0];
  assign if0.tft_data     = dat[0];
  assign busy_w[0]        = if0.tft_busy;
  assign if1.tft_transmit = tx[1];
  assign if1.tft_dc       = dcv[1];
  assign if1.tft_data     = dat[1];
  assign busy_w[1]        = if1.tft_busy;

  tft_spi_tx #(.CLK_DIV(2)) dut0 (
    .clk(clk), .global_reset_n(global_reset_n), .tft(if0.slave),
    .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_cs_n(csn[0]), .spi_dc(dcp[0]));

  tft_spi_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .global_reset_n(global_reset_n), .tft(if1.slave),
    .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_cs_n(csn[1]), .spi_dc(dcp[1]));

  // Monitor: bytes as seen by the panel, {dc_unstable, unit, dc, byte}
  logic [10:0] rx_mem [64];
  int          rx_wr = 0;
  bit   [1:0]  sck_p = '0;
  int          bcnt [2] = '{0, 0};
  logic [7:0]  shm  [2] = '{8'h00, 8'h00};
  bit   [1:0]  dc0  = '0;
  bit   [1:0]  unst = '0;
  int          rise_cnt [2] = '{0, 0};
  int          gap_cnt  [2] = '{0, 0};
  int          last_gap [2] = '{0, 0};

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      sck_p[u] <= sck[u];
      if (csn[u]) begin
        bcnt[u] <= 0;
        unst[u] <= 1'b0;
        if (gap_cnt[u] < 100000) gap_cnt[u] <= gap_cnt[u] + 1;
      end else begin
        if (gap_cnt[u] != 0) begin
          last_gap[u] <= gap_cnt[u];
          gap_cnt[u]  <= 0;
        end
        if (sck[u] && !sck_p[u]) begin
          rise_cnt[u] <= rise_cnt[u] + 1;
          shm[u]      <= {shm[u][6:0], mosi[u]};
          if (bcnt[u] == 0) dc0[u] <= dcp[u];
          if (bcnt[u] != 0 && dcp[u] != dc0[u]) unst[u] <= 1'b1;
          if (bcnt[u] == 7) begin
            rx_mem[rx_wr % 64] <= {unst[u] | (dcp[u] != dc0[u]), u[0], dc0[u], shm[u][6:0], mosi[u]};
            rx_wr   <= rx_wr + 1;
            bcnt[u] <= 0;
          end else begin
            bcnt[u] <= bcnt[u] + 1;
          end
        end
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;
  logic [10:0] exp_q [$];
  int rx_rd = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rx();
    logic [10:0] rec, e;
    while (rx_rd != rx_wr) begin
      rec = rx_mem[rx_rd % 64];
      rx_rd++;
      if (exp_q.size() == 0) chk("rx_unexpected_byte", int'(rec), -1);
      else begin
        e = exp_q.pop_front();
        chk("rx_byte", int'(rec), int'(e));
      end
    end
  endtask

  // Called on a negedge; returns on the first negedge where the unit reads not-busy.
  task automatic xfer(input int u, input logic d, input logic [7:0] b, input int inj,
                      output int bcyc, output int clow);
    int t;
    bcyc = 0;
    clow = 0;
    chk("busy_before_req", int'(busy_w[u]), 0);
    tx[u] = 1'b1; dcv[u] = d; dat[u] = b;
    #1;
    chk("busy_in_req_cycle", int'(busy_w[u]), 1);
    exp_q.push_back({1'b0, u[0], d, b});
    @(negedge clk);
    tx[u] = 1'b0;
    t = 0;
    while (busy_w[u] && t < 400) begin
      bcyc++;
      if (!csn[u]) clow++;
      if (t == inj) begin
        tx[u] = 1'b1; dat[u] = 8'h3C; dcv[u] = ~d;
      end else begin
        tx[u] = 1'b0; dat[u] = b; dcv[u] = d;
      end
      @(negedge clk);
      t++;
    end
    tx[u] = 1'b0;
    if (t >= 400) chk("busy_timeout", t, 0);
  endtask

  typedef struct {
    int         u;
    logic       dc;
    logic [7:0] data;
    int         inj;
    bit         b2b;
    int         exp_b;
    int         exp_c;
    int         exp_g;
  } vec_t;

  function automatic vec_t mk(input int u, input logic dc, input logic [7:0] data,
                              input int inj, input bit b2b);
    int div;
    vec_t v;
    div     = (u == 0) ? 2 : 1;
    v.u     = u; v.dc = dc; v.data = data; v.inj = inj; v.b2b = b2b;
    v.exp_b = BUSY_MUL * div;
    v.exp_c = 16 * div;
    v.exp_g = GAP_EN ? 2 * div + 1 : 1;
    return v;
  endfunction

  initial begin
    vec_t tbl [8];
    int bc, cl, r0, w0;
    tbl[0] = mk(0, 1'b0, 8'hA5, -1, 1'b0);
    tbl[1] = mk(0, 1'b1, 8'h2C, -1, 1'b1);
    tbl[2] = mk(0, 1'b1, 8'hFF, -1, 1'b1);
    tbl[3] = mk(0, 1'b1, 8'h00, -1, 1'b1);
    tbl[4] = mk(0, 1'b0, 8'hA5,  5, 1'b1);
    tbl[5] = mk(1, 1'b1, 8'hFF, -1, 1'b0);
    tbl[6] = mk(1, 1'b0, 8'h00, -1, 1'b1);
    tbl[7] = mk(1, 1'b1, 8'h96, -1, 1'b1);

    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_cs_n", int'(csn[u]), 1);
      chk("rst_sck", int'(sck[u]), 0);
      chk("rst_mosi", int'(mosi[u]), 0);
      chk("rst_dc", int'(dcp[u]), 0);
      chk("rst_busy", int'(busy_w[u]), 0);
    end
    global_reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      r0 = rise_cnt[tbl[i].u];
      xfer(tbl[i].u, tbl[i].dc, tbl[i].data, tbl[i].inj, bc, cl);
      chk("busy_cycles", bc, tbl[i].exp_b);
      chk("cs_low_cycles", cl, tbl[i].exp_c);
      chk("sck_rises", rise_cnt[tbl[i].u] - r0, 8);
      if (tbl[i].b2b) chk("cs_high_gap", last_gap[tbl[i].u], tbl[i].exp_g);
      check_rx();
    end

    // Reset ten cycles into a byte: pins must idle on the next edge, no byte delivered.
    w0 = rx_wr;
    tx[0] = 1'b1; dcv[0] = 1'b1; dat[0] = 8'h5A;
    @(negedge clk);
    tx[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_cs_low", int'(csn[0]), 0);
    global_reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_cs_n", int'(csn[0]), 1);
    chk("midrst_sck", int'(sck[0]), 0);
    chk("midrst_mosi", int'(mosi[0]), 0);
    chk("midrst_busy", int'(busy_w[0]), 0);
    global_reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_byte", rx_wr - w0, 0);
    r0 = rise_cnt[0];
    xfer(0, 1'b1, 8'h81, -1, bc, cl);
    chk("post_rst_busy_cycles", bc, BUSY_MUL * 2);
    chk("post_rst_sck_rises", rise_cnt[0] - r0, 8);
    check_rx();

    repeat (4) @(negedge clk);
    check_rx();
    chk("exp_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
